noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/noc_pkg.sv | 11 +
 rtl/noc_rr_arbiter.sv | 32 +++
 rtl/noc_output_arbiter.sv | 136 +++++++++++++
 tb/tb_noc_output_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types for the NoC output arbiter: FSM state encoding and counter width.
package noc_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  localparam int unsigned PktCountW = 16;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: search starts just after ptr_i and wraps,
// first asserted request wins; one-hot grant out, all-zero when nothing requests.
module noc_rr_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [PtrW:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    // Offset N revisits ptr_i itself, so the last winner is considered last.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (idx >= (PtrW + 1)'(N)) begin
        idx = idx - (PtrW + 1)'(N);
      end
      if (!found && req_i[idx[PtrW-1:0]]) begin
        gnt_o[idx[PtrW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin head grant, lock until last flit, registered output.
// Optional forwarded-packet counter enabled by defining NOC_ARB_PKT_COUNT_EN.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned INPUTS     = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUTS-1:0][FLIT_WIDTH-1:0]  in_flit,
  input  logic [INPUTS-1:0]                  in_last,
  input  logic [INPUTS-1:0]                  in_valid,
  output logic [INPUTS-1:0]                  in_ready,
  output logic [FLIT_WIDTH-1:0]              out_flit,
  output logic                               out_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PktCountW-1:0]               pkt_count
);

  localparam int unsigned PtrW = $clog2(INPUTS);

  arb_state_e            state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       owner_q, owner_d;
  logic [PtrW-1:0]       sel_idx, gnt_idx;
  logic [INPUTS-1:0]     gnt;
  logic                  slot_free, accept;
  logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  noc_rr_arbiter #(
    .N (INPUTS)
  ) u_rr (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (gnt[i]) begin
        gnt_idx = PtrW'(i);
      end
    end
  end

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    in_ready    = '0;
    sel_idx     = owner_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    out_flit_d  = out_flit_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        sel_idx  = gnt_idx;
        in_ready = gnt & {INPUTS{slot_free}};
      end
      StLocked: begin
        // Owner keeps the port even while it idles; others are never offered it.
        in_ready[owner_q] = slot_free;
      end
      default: ;
    endcase

    if (rst) begin
      in_ready = '0;
    end

    accept = |(in_ready & in_valid);

    if (accept) begin
      out_flit_d  = in_flit[sel_idx];
      out_last_d  = in_last[sel_idx];
      out_valid_d = 1'b1;
      if (state_q == StIdle) begin
        ptr_d = sel_idx;
        if (!in_last[sel_idx]) begin
          state_d = StLocked;
          owner_d = sel_idx;
        end
      end else if (in_last[sel_idx]) begin
        state_d = StIdle;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= PtrW'(INPUTS - 1);
      owner_q     <= '0;
      out_flit_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      out_flit_q  <= out_flit_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef NOC_ARB_PKT_COUNT_EN
  logic [PktCountW-1:0] pkt_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_q <= '0;
    end else if (out_valid_q && out_ready && out_last_q) begin
      pkt_count_q <= pkt_count_q + PktCountW'(1);
    end
  end

  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter (INPUTS=5, FLIT_WIDTH=32); hand-computed expectations.
module tb_noc_output_arbiter;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [4:0][31:0]     in_flit;
  logic [4:0]           in_last;
  logic [4:0]           in_valid;
  logic [4:0]           in_ready;
  logic [31:0]          out_flit;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          pkt_count;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  noc_output_arbiter #(
    .FLIT_WIDTH (32),
    .INPUTS     (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_count (pkt_count)
  );

  function automatic logic [31:0] mk(input int i, input int k);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] f, input logic l);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      check({tag, ".flit"}, out_flit, f);
      check({tag, ".last"}, 32'(out_last), 32'(l));
    end
  endtask

  logic [15:0] exp_cnt;

  initial begin
    rst       = 1'b1;
    in_valid  = 5'b11111;
    in_last   = 5'b11111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) in_flit[i] = mk(i, 0);

    // Reset: all valids high, nothing may be granted while rst is asserted.
    tick();
    tick();
    #1;
    check("rst.in_ready", 32'(in_ready), 32'h0);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.out_flit", out_flit, 32'h0);
    check("rst.out_last", 32'(out_last), 32'h0);
    check("rst.pkt_count", 32'(pkt_count), 32'h0);

    // Single-flit alternation between inputs 2 and 4.
    rst      = 1'b0;
    in_valid = 5'b10100;
    #1;
    check("rr.grant0", 32'(in_ready), 32'h04);
    tick();
    chk_out("rr.out0", 1'b1, mk(2, 0), 1'b1);
    check("rr.grant1", 32'(in_ready), 32'h10);
    tick();
    chk_out("rr.out1", 1'b1, mk(4, 0), 1'b1);
    check("rr.grant2", 32'(in_ready), 32'h04);
    tick();
    chk_out("rr.out2", 1'b1, mk(2, 0), 1'b1);
    check("rr.grant3", 32'(in_ready), 32'h10);
    tick();
    chk_out("rr.out3", 1'b1, mk(4, 0), 1'b1);

    // Wormhole: 4-flit packet from input 1 while input 3 waits.
    in_valid = 5'b01010;
    in_last  = 5'b01000;
    in_flit[3] = mk(3, 0);
    for (int k = 0; k < 4; k++) begin
      in_flit[1] = mk(1, k);
      in_last[1] = (k == 3);
      #1;
      check("lock.in_ready", 32'(in_ready), 32'h02);
      tick();
      chk_out("lock.out", 1'b1, mk(1, k), (k == 3));
    end
    #1;
    check("lock.release_grant", 32'(in_ready), 32'h08);
    tick();
    chk_out("lock.next_pkt", 1'b1, mk(3, 0), 1'b1);
    in_valid = 5'b00000;
    tick();
    check("drain.out_valid", 32'(out_valid), 32'h0);

    // Backpressure: 3 stalled cycles with a held flit.
    in_valid   = 5'b00001;
    in_last    = 5'b11111;
    in_flit[0] = mk(0, 0);
    tick();
    chk_out("stall.first", 1'b1, mk(0, 0), 1'b1);
    out_ready  = 1'b0;
    in_flit[0] = mk(0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall.in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("stall.hold", 1'b1, mk(0, 0), 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check("stall.resume_ready", 32'(in_ready), 32'h01);
    tick();
    chk_out("stall.resume1", 1'b1, mk(0, 1), 1'b1);
    in_flit[0] = mk(0, 2);
    tick();
    chk_out("stall.resume2", 1'b1, mk(0, 2), 1'b1);

    // Owner bubbles: input 2 pauses mid-packet while input 0 stays valid.
    in_valid   = 5'b00101;
    in_last    = 5'b00001;
    in_flit[0] = mk(0, 9);
    for (int k = 0; k < 2; k++) begin
      in_flit[2] = mk(2, k);
      #1;
      check("bub.in_ready", 32'(in_ready), 32'h04);
      tick();
      chk_out("bub.out", 1'b1, mk(2, k), 1'b0);
    end
    in_valid = 5'b00001;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bub.gap_ready", 32'(in_ready), 32'h04);
      tick();
      check("bub.bubble", 32'(out_valid), 32'h0);
    end
    in_valid   = 5'b00101;
    in_flit[2] = mk(2, 2);
    in_last[2] = 1'b1;
    tick();
    chk_out("bub.tail", 1'b1, mk(2, 2), 1'b1);
    check("bub.after_grant", 32'(in_ready), 32'h01);
    tick();
    chk_out("bub.input0", 1'b1, mk(0, 9), 1'b1);

    // Reset in the middle of a locked packet from input 3.
    in_valid   = 5'b01001;
    in_last    = 5'b00001;
    in_flit[3] = mk(3, 5);
    tick();
    chk_out("mrst.head", 1'b1, mk(3, 5), 1'b0);
    rst = 1'b1;
    #1;
    check("mrst.in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mrst.out_valid", 32'(out_valid), 32'h0);
    check("mrst.pkt_count", 32'(pkt_count), 32'h0);
    rst        = 1'b0;
    in_valid   = 5'b01010;
    in_last    = 5'b11111;
    in_flit[1] = mk(1, 7);
    #1;
    check("mrst.first_grant", 32'(in_ready), 32'h02);
    tick();
    chk_out("mrst.out", 1'b1, mk(1, 7), 1'b1);

    // Counter wrap: 65537 single-flit packets from input 0 after a fresh reset.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    in_valid   = 5'b00001;
    in_flit[0] = mk(0, 3);
    for (int n = 0; n < 65537; n++) tick();
    in_valid = 5'b00000;
    tick();
`ifdef NOC_ARB_PKT_COUNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    check("cnt.wrap", 32'(pkt_count), 32'(exp_cnt));
    check("cnt.idle_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
